// File: rtl/mole_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mole_scheduler
// Purpose  : Whack-a-mole scheduler. Spawns moles into random free holes,
//            times each raised mole on a prescaled tick, and scores whacks
//            (hits) and expirations (misses) with saturating counters.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK100MHZ   in   1        single rising-edge clock
//   reset       in   1        synchronous active-high reset
//   enable      in   1        spawn request (absorbed while one is pending)
//   difficulty  in   2        up-time divisor exponent, sampled at spawn
//   molehit     in   N_HOLES  whack strobes, one bit per hole
//   mole        out  N_HOLES  raised-mole mask
//   busy        out  1        a spawn request is pending
//   hit_pulse   out  1        one-cycle strobe for any hit this cycle
//   miss_pulse  out  1        one-cycle strobe for any timeout this cycle
//   hit_count   out  8        saturating hit counter
//   miss_count  out  8        saturating miss counter
// ============================================================================
module mole_scheduler #(
  parameter int          N_HOLES    = 8,
  parameter int          MAX_UP     = 3,
  parameter int          TICK_DIV   = 100000,
  parameter int          BASE_TICKS = 1024,
  parameter int          STEP_TICKS = 128,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic               CLK100MHZ,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         difficulty,
  input  logic [N_HOLES-1:0] molehit,
  output logic [N_HOLES-1:0] mole,
  output logic               busy,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [7:0]         hit_count,
  output logic [7:0]         miss_count
);

  localparam int          IDX_W = $clog2(N_HOLES);
  localparam int          TW    = $clog2(BASE_TICKS + 7 * STEP_TICKS + 1);
  localparam int          PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int          CW    = $clog2(N_HOLES + 1);
  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting)
  localparam logic [15:0] TAPS  = 16'hB400;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [15:0]        lfsr_q, lfsr_d;
  logic [PW-1:0]      pre_q, pre_d;
  logic               pending_q, pending_d;
  logic [N_HOLES-1:0] mole_q, mole_d;
  logic [TW-1:0]      timer_q [N_HOLES];
  logic               hit_pulse_q, hit_pulse_d;
  logic               miss_pulse_q, miss_pulse_d;
  logic [7:0]         hit_cnt_q, hit_cnt_d;
  logic [7:0]         miss_cnt_q, miss_cnt_d;

  // --------------------------------------------------------------------------
  // Combinational datapath
  // --------------------------------------------------------------------------
  logic               tick;
  logic [IDX_W-1:0]   cand;
  logic [2:0]         rnd;
  logic               cand_ok;
  logic               attempt;
  logic               success;
  logic [N_HOLES-1:0] hit_vec;
  logic [N_HOLES-1:0] to_vec;
  logic [N_HOLES-1:0] miss_vec;
  logic [N_HOLES-1:0] spawn_vec;
  logic [CW-1:0]      up_cnt;
  logic [CW-1:0]      hit_n;
  logic [CW-1:0]      miss_n;
  logic [TW-1:0]      base_sh;
  logic [TW-1:0]      step_sh;
  logic [TW-1:0]      load_val;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [CW-1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + 9'(b);
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  assign tick = (pre_q == PW'(TICK_DIV - 1));
  assign cand = lfsr_q[IDX_W-1:0];
  assign rnd  = lfsr_q[IDX_W+2:IDX_W];

  // When N_HOLES is a power of two every index is a real hole.
  generate
    if (N_HOLES == (1 << IDX_W)) begin : g_cand_full
      assign cand_ok = 1'b1;
    end else begin : g_cand_part
      assign cand_ok = (cand < IDX_W'(N_HOLES));
    end
  endgenerate

  always_comb begin
    up_cnt = '0;
    hit_n  = '0;
    miss_n = '0;
    for (int i = 0; i < N_HOLES; i++) begin
      hit_vec[i]  = molehit[i] & mole_q[i];
      to_vec[i]   = tick & mole_q[i] & (timer_q[i] == TW'(1));
      // A whack on an expiring hole counts as a hit only
      miss_vec[i] = to_vec[i] & ~hit_vec[i];
      up_cnt      = up_cnt + CW'(mole_q[i]);
      hit_n       = hit_n + CW'(hit_vec[i]);
      miss_n      = miss_n + CW'(miss_vec[i]);
    end
  end

  always_comb begin
    base_sh  = TW'(BASE_TICKS >> difficulty);
    step_sh  = TW'(STEP_TICKS >> difficulty);
    load_val = base_sh + TW'(rnd) * step_sh;
    if (load_val == '0) begin
      load_val = TW'(1);
    end
  end

  // Eligibility looks only at the mole state at the start of the cycle, so
  // a hole freed by a hit or timeout this cycle cannot be refilled until next.
  assign attempt   = enable | pending_q;
  assign success   = attempt & cand_ok & ~mole_q[cand] & (up_cnt < CW'(MAX_UP));
  assign spawn_vec = success ? (N_HOLES'(1) << cand) : '0;

  always_comb begin
    lfsr_d       = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
    pre_d        = tick ? '0 : pre_q + PW'(1);
    pending_d    = attempt & ~success;
    mole_d       = (mole_q & ~hit_vec & ~miss_vec) | spawn_vec;
    hit_pulse_d  = |hit_vec;
    miss_pulse_d = |miss_vec;
    hit_cnt_d    = sat_add(hit_cnt_q, hit_n);
    miss_cnt_d   = sat_add(miss_cnt_q, miss_n);
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      lfsr_q       <= SEED;
      pre_q        <= '0;
      pending_q    <= 1'b0;
      mole_q       <= '0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      for (int i = 0; i < N_HOLES; i++) begin
        timer_q[i] <= '0;
      end
    end else begin
      lfsr_q       <= lfsr_d;
      pre_q        <= pre_d;
      pending_q    <= pending_d;
      mole_q       <= mole_d;
      hit_pulse_q  <= hit_pulse_d;
      miss_pulse_q <= miss_pulse_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      for (int i = 0; i < N_HOLES; i++) begin
        if (spawn_vec[i]) begin
          timer_q[i] <= load_val;
        end else if (hit_vec[i] | to_vec[i]) begin
          timer_q[i] <= '0;
        end else if (tick & mole_q[i]) begin
          timer_q[i] <= timer_q[i] - TW'(1);
        end
      end
    end
  end

  assign mole       = mole_q;
  assign busy       = pending_q;
  assign hit_pulse  = hit_pulse_q;
  assign miss_pulse = miss_pulse_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mole_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mole_scheduler
// Purpose  : Directed self-checking bench for mole_scheduler with
//            N_HOLES=8, MAX_UP=3, TICK_DIV=4, BASE_TICKS=16, STEP_TICKS=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mole_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [1:0] diff = 2'd0;
  logic [7:0] hit = 8'h00;
  logic [7:0] mole;
  logic       busy;
  logic       hp;
  logic       mp;
  logic [7:0] hc;
  logic [7:0] mc;

  int n_chk = 0;
  int n_pass = 0;
  int exp_hits = 0;
  int exp_miss = 0;
  int cand;
  int rnd;
  int len;
  int cnt;
  logic [7:0] tgt;

  // Reference LFSR and prescaler, stepped from reset like the scheduler
  logic [15:0] lfsr_m;
  int          pre_m;

  always #5 clk = ~clk;

  mole_scheduler #(
    .N_HOLES    (8),
    .MAX_UP     (3),
    .TICK_DIV   (4),
    .BASE_TICKS (16),
    .STEP_TICKS (2),
    .SEED       (16'hACE1)
  ) dut (
    .CLK100MHZ  (clk),
    .reset      (rst),
    .enable     (en),
    .difficulty (diff),
    .molehit    (hit),
    .mole       (mole),
    .busy       (busy),
    .hit_pulse  (hp),
    .miss_pulse (mp),
    .hit_count  (hc),
    .miss_count (mc)
  );

  always @(posedge clk) begin
    if (rst) begin
      lfsr_m <= 16'hACE1;
      pre_m  <= 0;
    end else begin
      lfsr_m <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
      pre_m  <= (pre_m == 3) ? 0 : pre_m + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    // ---------------- reset overrides enable and whacks ----------------
    rst = 1'b1; en = 1'b1; hit = 8'hFF;
    repeat (3) step();
    check("rst_mole", mole, 0);
    check("rst_busy", busy, 0);
    check("rst_hit_pulse", hp, 0);
    check("rst_miss_pulse", mp, 0);
    check("rst_hit_count", hc, 0);
    check("rst_miss_count", mc, 0);
    rst = 1'b0; en = 1'b0; hit = 8'h00;
    check("rst_lfsr_seed", dut.lfsr_q, 16'hACE1);

    // ---------------- spawn and timeout ----------------
    cand = int'(lfsr_m[2:0]);
    rnd  = int'(lfsr_m[5:3]);
    len  = 16 + 2 * rnd;
    en = 1'b1; step(); en = 1'b0;
    check("spawn_mask", mole, 1 << cand);
    cnt = 0;
    while (mole != 8'h00 && cnt < 400) begin
      step();
      cnt++;
    end
    check("timeout_window", int'(cnt >= 4 * len - 3 && cnt <= 4 * len + 3), 1);
    check("timeout_miss_pulse", mp, 1);
    exp_miss = 1;
    check("timeout_miss_count", mc, exp_miss);
    step();
    check("miss_pulse_single", mp, 0);

    // ---------------- hit ----------------
    cand = int'(lfsr_m[2:0]);
    en = 1'b1; step(); en = 1'b0;
    check("hit_spawn_mask", mole, 1 << cand);
    hit = ~mole; step(); hit = 8'h00;
    check("lowered_whack_count", hc, 0);
    check("lowered_whack_mole", mole, 1 << cand);
    hit = mole; step(); hit = 8'h00;
    exp_hits = 1;
    check("hit_mole_clear", mole, 0);
    check("hit_pulse", hp, 1);
    check("hit_count", hc, exp_hits);
    check("hit_miss_unchanged", mc, exp_miss);
    step();
    check("hit_pulse_single", hp, 0);

    // ---------------- capacity ----------------
    for (int k = 0; k < 3; k++) begin
      en = 1'b1; step(); en = 1'b0; step();
      cnt = 0;
      while (busy && cnt < 50) begin
        step();
        cnt++;
      end
    end
    check("cap_three_up", $countones(mole), 3);
    en = 1'b1; step(); en = 1'b0; step();
    check("cap_busy_full", busy, 1);
    check("cap_still_three", $countones(mole), 3);
    tgt = mole & (~mole + 8'd1);
    hit = tgt; step(); hit = 8'h00;
    exp_hits++;
    check("cap_freed_not_reused", $countones(mole), 2);
    check("cap_busy_after_hit", busy, 1);
    cnt = 0;
    while (busy && cnt < 50) begin
      step();
      cnt++;
    end
    check("cap_busy_cleared", busy, 0);
    check("cap_fourth_spawned", $countones(mole), 3);
    check("cap_hit_count", hc, exp_hits);
    exp_hits += $countones(mole);
    hit = mole; step(); hit = 8'h00;
    check("multi_hit_clear", mole, 0);
    check("multi_hit_count", hc, exp_hits);
    check("multi_hit_pulse", hp, 1);

    // ---------------- hit and timeout on the same hole ----------------
    diff = 2'd3; en = 1'b1; step(); en = 1'b0; diff = 2'd0;
    check("coll_spawn", $countones(mole), 1);
    while (pre_m != 3) step();
    step();
    check("coll_after_first_tick", $countones(mole), 1);
    while (pre_m != 3) step();
    hit = mole; step(); hit = 8'h00;
    exp_hits++;
    check("coll_mole_clear", mole, 0);
    check("coll_hit_count", hc, exp_hits);
    check("coll_miss_count", mc, exp_miss);
    check("coll_no_miss_pulse", mp, 0);

    // ---------------- difficulty 3 lasts 2 ticks ----------------
    diff = 2'd3; en = 1'b1; step(); en = 1'b0; diff = 2'd0;
    check("diff3_spawn", $countones(mole), 1);
    cnt = 0;
    while (mole != 8'h00 && cnt < 100) begin
      step();
      cnt++;
    end
    exp_miss++;
    check("diff3_window", int'(cnt >= 5 && cnt <= 11), 1);
    check("diff3_miss_count", mc, exp_miss);

    // ---------------- hit counter saturation ----------------
    for (int k = 0; k < 300; k++) begin
      en = 1'b1; step(); en = 1'b0;
      hit = mole; step(); hit = 8'h00;
      if (exp_hits < 255) exp_hits++;
      if (k == 100) check("sat_mid_count", hc, exp_hits);
    end
    check("sat_hit_count", hc, 255);
    check("sat_miss_unchanged", mc, exp_miss);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
